// File: rtl/vga_sync.sv
// ============================================================================
// vga_sync : VGA timing generator with registered sync, blanking, coordinates
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_vis;

  // Wrap by explicit compare so non-power-of-two totals never rely on overflow.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_h_next = w_h_wrap ? '0 : r_h + ONE;
    w_v_next = r_v;
    if (w_h_wrap) begin
      w_v_next = (r_v == V_LAST) ? '0 : r_v + ONE;
    end
    w_hs_act = (r_h >= HS_BEG) && (r_h < HS_END);
    w_vs_act = (r_v >= VS_BEG) && (r_v < VS_END);
    w_vis    = (r_h < H_VIS) && (r_v < V_VIS);
  end

  // Outputs are the registered decode of the counter state before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_h         <= w_h_next;
      r_v         <= w_v_next;
      hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      video_on    <= w_vis;
      x           <= r_h;
      y           <= r_v;
      line_start  <= (r_h == '0);
      frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// ============================================================================
// tb_vga_sync : scoreboard + directed checks for vga_sync (default, small, pol)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;  // 15
  localparam int SVT = SVA + SVF + SVS + SVB;  // 10

  localparam logic [36:0] RST_LOW  = {2'b11, 3'b000, 32'd0};
  localparam logic [36:0] RST_HIGH = {2'b00, 3'b000, 32'd0};
  localparam logic [36:0] ORG_LOW  = {2'b11, 3'b111, 32'd0};
  localparam logic [36:0] ORG_HIGH = {2'b00, 3'b111, 32'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       hs0, vs0, vo0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vo1, ls1, fs1;
  logic [3:0] x1, y1;
  logic       hs2, vs2, vo2, ls2, fs2;
  logic [3:0] x2, y2;

  vga_sync u_def (
    .clk(clk), .rst_n(rst_n), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_sync #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0), .CW(4)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  vga_sync #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1), .CW(4)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .hsync(hs2), .vsync(vs2), .video_on(vo2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
  );

  wire [36:0] obs0 = {hs0, vs0, vo0, ls0, fs0, 6'd0, x0, 6'd0, y0};
  wire [36:0] obs1 = {hs1, vs1, vo1, ls1, fs1, 12'd0, x1, 12'd0, y1};
  wire [36:0] obs2 = {hs2, vs2, vo2, ls2, fs2, 12'd0, x2, 12'd0, y2};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] dec(input int h, input int v, input int ha, input int hf,
                                      input int hsw, input int va, input int vf, input int vsw,
                                      input bit pol);
    logic hsa, vsa;
    hsa = (h >= ha + hf) && (h < ha + hf + hsw);
    vsa = (v >= va + vf) && (v < va + vf + vsw);
    return {hsa ? pol : ~pol, vsa ? pol : ~pol, (h < ha) && (v < va),
            h == 0, (h == 0) && (v == 0), 16'(h), 16'(v)};
  endfunction

  // Reference counters; expected decode is queued at each edge, checked half a cycle later.
  logic [36:0] q0[$], q1[$], q2[$];
  int mh0, mv0, mh1, mv1;

  always @(negedge rst_n) begin
    q0.delete(); q1.delete(); q2.delete();
    mh0 = 0; mv0 = 0; mh1 = 0; mv1 = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      q0.push_back(dec(mh0, mv0, 640, 16, 96, 480, 10, 2, 1'b0));
      q1.push_back(dec(mh1, mv1, SHA, SHF, SHS, SVA, SVF, SVS, 1'b0));
      q2.push_back(dec(mh1, mv1, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1));
      if (mh0 == 799) begin
        mh0 = 0;
        mv0 = (mv0 == 524) ? 0 : mv0 + 1;
      end else mh0 = mh0 + 1;
      if (mh1 == SHT - 1) begin
        mh1 = 0;
        mv1 = (mv1 == SVT - 1) ? 0 : mv1 + 1;
      end else mh1 = mh1 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      chk("sb_def_rst", obs0, RST_LOW);
      chk("sb_sml_rst", obs1, RST_LOW);
      chk("sb_pol_rst", obs2, RST_HIGH);
    end else if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
      chk("sb_queue_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd3);
    end else begin
      chk("sb_def", obs0, q0.pop_front());
      chk("sb_sml", obs1, q1.pop_front());
      chk("sb_pol", obs2, q2.pop_front());
    end
  end

  int vo_cnt, hs_cnt, hs_first, ls_cnt;
  int vsl, badedge, ymax, badvo, extra_fs, px, py, pol_hs, pol_bad, pol_vs;
  logic prev_vs;
  bit found;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hsync", 64'(hs0), 64'd1);
    chk("rst_vsync", 64'(vs0), 64'd1);
    chk("rst_video_on", 64'(vo0), 64'd0);
    chk("rst_x", 64'(x0), 64'd0);
    chk("rst_y", 64'(y0), 64'd0);
    chk("rst_pol_syncs", 64'({hs2, vs2}), 64'd0);

    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_frame_start", 64'(fs0), 64'd1);
    chk("first_line_start", 64'(ls0), 64'd1);
    chk("first_video_on", 64'(vo0), 64'd1);
    chk("first_xy", 64'({x0, y0}), 64'd0);

    // One full default line starting at x=0.
    vo_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (vo0) vo_cnt++;
      if (!hs0) begin
        if (hs_first < 0) hs_first = int'(x0);
        hs_cnt++;
      end
      if (ls0) ls_cnt++;
    end
    chk("line_video_clocks", 64'(vo_cnt), 64'd640);
    chk("line_hsync_clocks", 64'(hs_cnt), 64'd96);
    chk("line_hsync_first_x", 64'(hs_first), 64'd656);
    chk("line_start_count", 64'(ls_cnt), 64'd1);
    @(negedge clk);
    chk("line_start_period", 64'({ls0, x0, y0}), {53'd0, 1'b1, 10'd0, 10'd1});

    // Align to a small-instance frame start.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (fs1) found = 1'b1;
    end
    chk("sml_frame_start_seen", 64'(found), 64'd1);

    vsl = 0; badedge = 0; ymax = 0; badvo = 0; extra_fs = 0;
    pol_hs = 0; pol_bad = 0; pol_vs = 0; prev_vs = vs1;
    for (int i = 0; i < SHT * SVT; i++) begin
      if (i > 0) @(negedge clk);
      if (!vs1) vsl++;
      if (vs1 != prev_vs && x1 != 4'd0) badedge++;
      prev_vs = vs1;
      if (int'(y1) > ymax) ymax = int'(y1);
      if (vo1 && y1 >= 4'(SVA)) badvo++;
      if (i > 0 && fs1) extra_fs++;
      if (hs2) begin
        pol_hs++;
        if (x2 < 4'(SHA + SHF) || x2 >= 4'(SHA + SHF + SHS)) pol_bad++;
      end
      if (vs2) pol_vs++;
      px = int'(x1);
      py = int'(y1);
    end
    chk("sml_vsync_clocks", 64'(vsl), 64'(SVS * SHT));
    chk("sml_vsync_edge_x0", 64'(badedge), 64'd0);
    chk("sml_y_max", 64'(ymax), 64'(SVT - 1));
    chk("sml_blank_rows", 64'(badvo), 64'd0);
    chk("sml_no_early_frame", 64'(extra_fs), 64'd0);
    chk("pol_hsync_clocks", 64'(pol_hs), 64'(SHS * SVT));
    chk("pol_hsync_window", 64'(pol_bad), 64'd0);
    chk("pol_vsync_clocks", 64'(pol_vs), 64'(SVS * SHT));
    @(negedge clk);
    chk("sml_frame_period", 64'(fs1), 64'd1);
    chk("sml_wrap_from", 64'({px, py}), {32'(SHT - 1), 32'(SVT - 1)});
    chk("sml_wrap_to", 64'({x1, y1}), 64'd0);

    // Mid-frame asynchronous reset between edges.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (x1 == 4'd5 && y1 == 4'd3) found = 1'b1;
    end
    chk("mid_point_seen", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sml", obs1, RST_LOW);
    chk("mid_rst_def", obs0, RST_LOW);
    chk("mid_rst_pol", obs2, RST_HIGH);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("restart_sml", obs1, ORG_LOW);
    chk("restart_def", obs0, ORG_LOW);
    chk("restart_pol", obs2, ORG_HIGH);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync.md
# vga_sync

VGA timing generator clocked by the 25 MHz pixel clock produced by `clkdiv` (`clk25`). It holds horizontal and vertical counters, and drives registered sync, blanking, pixel-coordinate and frame/line marker outputs. The pixel renderer and the VGA output pins consume these outputs. Defaults give 640x480 at 60 Hz: 800 clocks per line and 525 lines per frame.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in clocks
- `H_SYNC`, default 96: hsync pulse width, in clocks
- `H_BP`, default 48: horizontal back porch, in clocks
- `V_ACTIVE`, default 480: visible lines per frame
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync pulse width, in lines
- `V_BP`, default 33: vertical back porch, in lines
- `SYNC_POL`, default 0: asserted level of hsync/vsync (0 = active-low)
- `CW`, default 10: counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

- `clk`  in  1  pixel clock; connected to `clkdiv.clk25`
- `rst_n`  in  1  asynchronous, active-low reset
- `hsync`  out  1  horizontal sync, at SYNC_POL while asserted
- `vsync`  out  1  vertical sync, at SYNC_POL while asserted
- `video_on`  out  1  high during visible region
- `x`  out  CW  horizontal counter value (0..H_TOTAL-1)
- `y`  out  CW  vertical counter value (0..V_TOTAL-1)
- `line_start`  out  1  one-clock pulse when x==0
- `frame_start`  out  1  one-clock pulse when x==0 and y==0

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Internal `h_cnt`:
  - increments every clk
  - wraps H_TOTAL-1 -> 0
- Internal `v_cnt`:
  - increments only when h_cnt wraps
  - wraps V_TOTAL-1 -> 0
  - simultaneous wrap of both counters (end of frame) -> both 0 on the same edge
- Decode from the counter state h, v:
  - hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491)
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE)
  - x = h, y = v; x/y are not masked in blanking
  - line_start = (h == 0)
  - frame_start = (h == 0 && v == 0)
- No enable input: the block free-runs from reset release.
- Counter arithmetic is unsigned CW-bit. Wrap uses an explicit compare to TOTAL-1, never natural overflow.

## Timing
- All outputs are flops loaded from the decode of the current counter state. Each output therefore shows the state the counters held one clk earlier (latency 1).
- Reset (rst_n low, asynchronous, any time including mid-frame):
  - h_cnt=0, v_cnt=0
  - hsync = vsync = ~SYNC_POL (deasserted; 1 for defaults)
  - video_on=0, x=0, y=0, line_start=0, frame_start=0
- First rising clk after rst_n deasserts:
  - outputs load the decode of h=0, v=0: video_on=1, x=0, y=0, line_start=1, frame_start=1
  - h_cnt becomes 1
- Steady state:
  - line_start period = H_TOTAL clocks
  - frame_start period = H_TOTAL*V_TOTAL = 420000 clocks
- hsync:
  - asserted for exactly H_SYNC consecutive clocks per line
  - first asserted output cycle shows x=656
- vsync:
  - asserted for V_SYNC*H_TOTAL = 1600 consecutive clocks
  - asserts and deasserts in the same clock that x becomes 0
- An rst_n assertion mid-line forces all outputs to their reset values immediately, with no clock required. After release, counting restarts at 0,0.

## Test plan
- Reset then release:
  - during reset: hsync=1, vsync=1, video_on=0, x=y=0
  - first edge after release: frame_start=1, line_start=1, video_on=1, x=0, y=0
- One line:
  - video_on high for exactly 640 clocks from x=0
  - hsync low from x=656 through x=751 (96 clocks)
  - line_start returns after exactly 800 clocks
- Full frame:
  - frame_start pulses are 420000 clocks apart
  - y reaches 524 then returns to 0 together with x 799->0
- Vsync:
  - vsync low only while y in {490,491}: 1600 clocks
  - video_on=0 for every clock with y>=480
- Mid-frame reset:
  - assert rst_n at x=300, y=200 between clock edges -> outputs go to reset values before the next edge
  - after release the sequence restarts at x=0, y=0 with frame_start=1
- Polarity override (SYNC_POL=1):
  - hsync/vsync idle low and pulse high over the same x/y windows
